// File: rtl/vga_rx_monitor.sv
// -----------------------------------------------------------------------------
// vga_rx_monitor
//
// Purpose
//   Passive monitor for a VGA-style video stream. It registers the sync and
//   colour pins once, measures line length and frame height from the sync
//   leading edges, and runs a SEARCH -> ACQUIRE -> LOCKED tracker. It checks
//   the measured timing against the parameters. While locked it emits the
//   active pixels with their (x, y) coordinates. Pixel outputs appear two
//   clocks after the pins.
//
//   Optional feature: define VGA_RX_MONITOR_CRC_EN to build a per-frame
//   CRC-16-CCITT over the emitted pixels. The polynomial is 0x1021, the
//   initial value is 0xFFFF, there is no reflection, and each pixel feeds
//   12 bits MSB first. When the macro is undefined, frame_crc is tied to 0
//   and no CRC logic exists.
//
// Parameters
//   H_TOTAL / V_TOTAL             expected pixels per line / lines per frame
//   H_ACTIVE / V_ACTIVE           active pixels per line / active lines
//   H_SYNC_TO_ACT / V_SYNC_TO_ACT offset from sync leading edge to first
//                                 active pixel / line
//   SYNC_POL                      asserted level of hs and vs
//
// Ports
//   clk, rst_n        pixel clock, asynchronous active-low reset
//   hs, vs            horizontal / vertical sync inputs
//   r, g, b           4-bit colour inputs
//   pix_valid         pix_x / pix_y / pix_rgb carry an active pixel
//   pix_x, pix_y      active column / row
//   pix_rgb           {r,g,b} of that pixel
//   locked            timing matches the parameters
//   line_len          measured length of the last line
//   frame_lines       measured line count of the last frame
//   frame_done        one-cycle pulse on each frame end that leaves us locked
//   err_cnt           saturating count of lock losses
//   frame_crc         pixel CRC of the last frame (0 when CRC is not built)
// -----------------------------------------------------------------------------
module vga_rx_monitor #(
    parameter int   H_TOTAL       = 1056,
    parameter int   V_TOTAL       = 628,
    parameter int   H_ACTIVE      = 800,
    parameter int   V_ACTIVE      = 600,
    parameter int   H_SYNC_TO_ACT = 216,
    parameter int   V_SYNC_TO_ACT = 27,
    parameter logic SYNC_POL      = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hs,
    input  logic        vs,
    input  logic [3:0]  r,
    input  logic [3:0]  g,
    input  logic [3:0]  b,
    output logic        pix_valid,
    output logic [10:0] pix_x,
    output logic [10:0] pix_y,
    output logic [11:0] pix_rgb,
    output logic        locked,
    output logic [10:0] line_len,
    output logic [10:0] frame_lines,
    output logic        frame_done,
    output logic [7:0]  err_cnt,
    output logic [15:0] frame_crc
);

    // Window bounds are carried at 12 bits, so hcnt+1 never wraps in a
    // comparison.
    localparam logic [11:0] H_TOTAL_W = 12'(H_TOTAL);
    localparam logic [11:0] V_TOTAL_W = 12'(V_TOTAL);
    localparam logic [11:0] H_ACT_LO  = 12'(H_SYNC_TO_ACT);
    localparam logic [11:0] H_ACT_HI  = 12'(H_SYNC_TO_ACT + H_ACTIVE);
    localparam logic [11:0] V_ACT_LO  = 12'(V_SYNC_TO_ACT);
    localparam logic [11:0] V_ACT_HI  = 12'(V_SYNC_TO_ACT + V_ACTIVE);
    localparam logic [10:0] CNT_MAX   = 11'h7FF;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Input stage and edge-detect history
    logic        hs_q;
    logic        vs_q;
    logic        hs_d;
    logic        vs_d;
    logic [11:0] rgb_q;
    logic        hs_edge;
    logic        vs_edge;

    // Timing counters
    logic [10:0] hcnt;
    logic [10:0] vcnt;
    logic [10:0] hcnt_nxt;
    logic [10:0] vcnt_nxt;
    logic [11:0] hcnt_p1;
    logic [11:0] vcnt_p1;

    // Lock-tracking bookkeeping
    logic        hs_seen;
    logic        line_ok;
    logic        line_ok_nxt;
    logic        line_bad;
    logic        frame_bad;
    logic        lose_lock;
    logic        frame_done_nxt;

    // Pixel window
    logic        in_h;
    logic        in_v;
    logic        pix_valid_nxt;
    logic [11:0] pix_x_full;
    logic [11:0] pix_y_full;

    // -------------------------------------------------------------------------
    // Edge detection on the registered syncs
    // -------------------------------------------------------------------------
    assign hs_edge = (hs_q == SYNC_POL) && (hs_d != SYNC_POL);
    assign vs_edge = (vs_q == SYNC_POL) && (vs_d != SYNC_POL);

    // -------------------------------------------------------------------------
    // Counter next-state. hcnt_nxt/vcnt_nxt are the coordinates of the sample
    // now sitting in rgb_q. The pixel window is evaluated on these values, so
    // position and colour stay aligned.
    // -------------------------------------------------------------------------
    always_comb begin
        hcnt_p1  = {1'b0, hcnt} + 12'd1;
        vcnt_p1  = {1'b0, vcnt} + 12'd1;
        hcnt_nxt = hcnt;
        vcnt_nxt = vcnt;

        if (hs_edge) begin
            hcnt_nxt = '0;
        end else if (hcnt != CNT_MAX) begin
            hcnt_nxt = hcnt_p1[10:0];
        end

        // A VS edge takes priority over a coincident HS edge.
        if (vs_edge) begin
            vcnt_nxt = '0;
        end else if (hs_edge && (vcnt != CNT_MAX)) begin
            vcnt_nxt = vcnt_p1[10:0];
        end
    end

    // -------------------------------------------------------------------------
    // Timing checks. The first HS edge after reset closes a line of unknown
    // length, so line checks start only after it.
    // -------------------------------------------------------------------------
    assign line_bad  = hs_edge && hs_seen && (hcnt_p1 != H_TOTAL_W);
    assign frame_bad = vs_edge && (vcnt_p1 != V_TOTAL_W);

    // -------------------------------------------------------------------------
    // Lock FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEARCH;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Lock FSM: next state and side outputs.
    // line_ok records whether every line of the current frame was the right
    // length. A mid-frame lock loss clears it, so the damaged frame cannot
    // relock at its own end. A clean frame must follow before lock returns.
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt      = state;
        lose_lock      = 1'b0;
        frame_done_nxt = 1'b0;
        line_ok_nxt    = line_ok;

        if (vs_edge) begin
            line_ok_nxt = 1'b1;
        end else if (line_bad) begin
            line_ok_nxt = 1'b0;
        end

        case (state)
            SEARCH: begin
                if (vs_edge) begin
                    state_nxt = ACQUIRE;
                end
            end
            ACQUIRE: begin
                // The HS edge coinciding with VS closes the frame's last line.
                if (vs_edge && line_ok && !line_bad && !frame_bad) begin
                    state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                if (line_bad || frame_bad) begin
                    state_nxt = ACQUIRE;
                    lose_lock = 1'b1;
                end
            end
            default: begin
                state_nxt = SEARCH;
            end
        endcase

        frame_done_nxt = vs_edge && (state_nxt == LOCKED);
    end

    assign locked = (state == LOCKED);

    // -------------------------------------------------------------------------
    // Pixel window, evaluated on the coordinates of the sample in rgb_q
    // -------------------------------------------------------------------------
    always_comb begin
        in_h          = ({1'b0, hcnt_nxt} >= H_ACT_LO) && ({1'b0, hcnt_nxt} < H_ACT_HI);
        in_v          = ({1'b0, vcnt_nxt} >= V_ACT_LO) && ({1'b0, vcnt_nxt} < V_ACT_HI);
        pix_valid_nxt = (state == LOCKED) && in_h && in_v;
        pix_x_full    = {1'b0, hcnt_nxt} - H_ACT_LO;
        pix_y_full    = {1'b0, vcnt_nxt} - V_ACT_LO;
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Reset the sync history to the asserted level. A sync still
            // asserted at release then gives no spurious leading edge.
            hs_q        <= SYNC_POL;
            vs_q        <= SYNC_POL;
            hs_d        <= SYNC_POL;
            vs_d        <= SYNC_POL;
            rgb_q       <= '0;
            hcnt        <= '0;
            vcnt        <= '0;
            line_len    <= '0;
            frame_lines <= '0;
            hs_seen     <= 1'b0;
            line_ok     <= 1'b0;
            err_cnt     <= '0;
            frame_done  <= 1'b0;
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_rgb     <= '0;
        end else begin
            hs_q    <= hs;
            vs_q    <= vs;
            hs_d    <= hs_q;
            vs_d    <= vs_q;
            rgb_q   <= {r, g, b};
            hcnt    <= hcnt_nxt;
            vcnt    <= vcnt_nxt;
            line_ok <= line_ok_nxt;

            if (hs_edge) begin
                line_len <= hcnt_p1[10:0];
                hs_seen  <= 1'b1;
            end
            if (vs_edge) begin
                frame_lines <= vcnt_p1[10:0];
            end

            if (lose_lock && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end

            frame_done <= frame_done_nxt;

            pix_valid <= pix_valid_nxt;
            if (pix_valid_nxt) begin
                pix_x   <= pix_x_full[10:0];
                pix_y   <= pix_y_full[10:0];
                pix_rgb <= rgb_q;
            end else begin
                pix_x   <= '0;
                pix_y   <= '0;
                pix_rgb <= '0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Frame CRC (optional)
    // -------------------------------------------------------------------------
`ifdef VGA_RX_MONITOR_CRC_EN
    logic [15:0] crc;
    logic [15:0] crc_upd;

    // One pixel per clock: twelve serial CRC steps unrolled, MSB first.
    function automatic logic [15:0] crc16_step12(input logic [15:0] crc_in,
                                                 input logic [11:0] data);
        logic [15:0] c;
        c = crc_in;
        for (int i = 11; i >= 0; i--) begin
            c = {c[14:0], 1'b0} ^ ((c[15] ^ data[i]) ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    always_comb begin
        crc_upd = crc;
        if (pix_valid) begin
            crc_upd = crc16_step12(crc, pix_rgb);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc       <= 16'hFFFF;
            frame_crc <= 16'h0000;
        end else if (vs_edge) begin
            frame_crc <= crc_upd;
            crc       <= 16'hFFFF;
        end else begin
            crc       <= crc_upd;
        end
    end
`else
    assign frame_crc = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_rx_monitor.sv
// -----------------------------------------------------------------------------
// tb_vga_rx_monitor
//
// Drives a scaled-down VGA raster. Each line is 12 clocks and each frame is
// 6 lines. The active window is 6x3, starting at hcnt 3 and vcnt 2. Expected
// pixels are pushed into exp_q as they are driven, stamped with the cycle on
// which they must appear. A separate monitor pops and compares whenever
// pix_valid is high. Status outputs are compared against hand-derived values
// at frame boundaries.
// -----------------------------------------------------------------------------
module tb_vga_rx_monitor;

    localparam int HT  = 12;
    localparam int VT  = 6;
    localparam int HA  = 6;
    localparam int VA  = 3;
    localparam int HSA = 3;
    localparam int VSA = 2;
    localparam int W   = 66;   // {cycle[31:0], x[10:0], y[10:0], rgb[11:0]}

    // ---------------- clock / reset ----------------
    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        hs    = 1'b0;
    logic        vs    = 1'b0;
    logic [3:0]  r     = '0;
    logic [3:0]  g     = '0;
    logic [3:0]  b     = '0;
    logic        pix_valid;
    logic [10:0] pix_x;
    logic [10:0] pix_y;
    logic [11:0] pix_rgb;
    logic        locked;
    logic [10:0] line_len;
    logic [10:0] frame_lines;
    logic        frame_done;
    logic [7:0]  err_cnt;
    logic [15:0] frame_crc;

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    vga_rx_monitor #(
        .H_TOTAL      (HT),
        .V_TOTAL      (VT),
        .H_ACTIVE     (HA),
        .V_ACTIVE     (VA),
        .H_SYNC_TO_ACT(HSA),
        .V_SYNC_TO_ACT(VSA),
        .SYNC_POL     (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hs         (hs),
        .vs         (vs),
        .r          (r),
        .g          (g),
        .b          (b),
        .pix_valid  (pix_valid),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_rgb    (pix_rgb),
        .locked     (locked),
        .line_len   (line_len),
        .frame_lines(frame_lines),
        .frame_done (frame_done),
        .err_cnt    (err_cnt),
        .frame_crc  (frame_crc)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];
    int done_cnt = 0;

    // Pixel pattern controls
    bit          pat_zero = 1'b0;
    bit          poke_en  = 1'b0;
    int          poke_x   = 0;
    int          poke_y   = 0;
    logic [11:0] poke_val = '0;
    logic [3:0]  pat_seed = 4'h1;
    logic [15:0] ref_crc      = 16'hFFFF;
    logic [15:0] last_ref_crc = 16'hFFFF;

    function automatic logic [15:0] crc12(input logic [15:0] c, input logic [11:0] d);
        logic [15:0] v;
        v = c;
        for (int i = 11; i >= 0; i--) begin
            if (v[15] ^ d[i]) v = {v[14:0], 1'b0} ^ 16'h1021;
            else              v = {v[14:0], 1'b0};
        end
        return v;
    endfunction

    function automatic logic [11:0] pix_of(input int x, input int y);
        logic [3:0] xs;
        logic [3:0] ys;
        xs = 4'(x);
        ys = 4'(y);
        if (poke_en && x == poke_x && y == poke_y) return poke_val;
        if (pat_zero) return 12'h000;
        return {xs ^ pat_seed, ys, pat_seed};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // ---------------- driver ----------------
    // Drives one frame. short_line (or -1) is one clock short. lock_exp says
    // the DUT should be locked at the start of this frame. Pixels on lines
    // after a short line are not expected, because lock drops there.
    task automatic drive_frame(input int nlines, input int short_line, input bit lock_exp);
        ref_crc = 16'hFFFF;
        for (int ln = 0; ln < nlines; ln++) begin
            int len;
            len = (ln == short_line) ? HT - 1 : HT;
            for (int c = 0; c < len; c++) begin
                int x;
                int y;
                bit act;
                logic [11:0] px;
                @(negedge clk);
                x   = c - HSA;
                y   = ln - VSA;
                act = (x >= 0) && (x < HA) && (y >= 0) && (y < VA);
                px  = act ? pix_of(x, y) : 12'h5A5;
                hs  = (c < 2);
                vs  = (ln == 0) && (c < 2);
                {r, g, b} = px;
                if (act && lock_exp && (short_line < 0 || ln <= short_line)) begin
                    exp_q.push_back({cyc + 32'd2, 11'(x), 11'(y), px});
                    ref_crc = crc12(ref_crc, px);
                end
            end
        end
        last_ref_crc = ref_crc;
    endtask

    // ---------------- monitor ----------------
    logic [W-1:0] mon_e;
    logic [W-1:0] mon_a;
    always @(negedge clk) begin
        if (frame_done === 1'b1) done_cnt++;
        if (pix_valid === 1'b1) begin
            total++;
            mon_a = {cyc, pix_x, pix_y, pix_rgb};
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pix_unexpected: got x=%0d y=%0d rgb=%h cyc=%0d, expected no pixel",
                         pix_x, pix_y, pix_rgb, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_a !== mon_e) begin
                    bad++;
                    $display("FAIL pix_data: got cyc=%0d x=%0d y=%0d rgb=%h, expected cyc=%0d x=%0d y=%0d rgb=%h",
                             mon_a[65:34], mon_a[33:23], mon_a[22:12], mon_a[11:0],
                             mon_e[65:34], mon_e[33:23], mon_e[22:12], mon_e[11:0]);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected test end");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    logic [15:0] crc_a;
    logic [15:0] crc_b;
    logic [15:0] dut_crc_a;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_locked",      32'(locked),      32'd0);
        check("rst_pix_valid",   32'(pix_valid),   32'd0);
        check("rst_line_len",    32'(line_len),    32'd0);
        check("rst_frame_lines", 32'(frame_lines), 32'd0);
        check("rst_err_cnt",     32'(err_cnt),     32'd0);
        check("rst_frame_done",  32'(frame_done),  32'd0);
        check("rst_frame_crc",   32'(frame_crc),   32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal lock. The first VS goes to ACQUIRE and the second locks.
        // (0,0) in the first locked frame carries 12'hABC.
        drive_frame(VT, -1, 1'b0);
        check("lock_after_vs1", 32'(locked), 32'd0);
        poke_en = 1'b1; poke_x = 0; poke_y = 0; poke_val = 12'hABC; pat_seed = 4'h2;
        drive_frame(VT, -1, 1'b1);
        poke_en = 1'b0;
        check("lock_after_vs2",  32'(locked),      32'd1);
        check("line_len_nom",    32'(line_len),    32'(HT));
        check("frame_lines_nom", 32'(frame_lines), 32'(VT));
        check("frame_done_1",    32'(done_cnt),    32'd1);
        pat_seed = 4'h7;
        drive_frame(VT, -1, 1'b1);
        check("frame_done_2",    32'(done_cnt),    32'd2);
        check("err_before_line", 32'(err_cnt),     32'd0);

        // Line error: line 3 is one clock short.
        pat_seed = 4'h9;
        drive_frame(VT, 3, 1'b1);
        check("line_err_locked", 32'(locked), 32'd0);
        check("line_err_cnt",    32'(err_cnt), 32'd1);
        drive_frame(VT, -1, 1'b0);
        check("line_err_noearly", 32'(locked), 32'd0);
        drive_frame(VT, -1, 1'b1);
        check("line_err_relock", 32'(locked), 32'd1);

        // Frame error: one frame is a line short.
        pat_seed = 4'hC;
        drive_frame(VT - 1, -1, 1'b1);
        drive_frame(VT, -1, 1'b0);
        check("frame_err_locked", 32'(locked),      32'd0);
        check("frame_err_cnt",    32'(err_cnt),     32'd2);
        check("frame_err_lines",  32'(frame_lines), 32'(VT - 1));
        drive_frame(VT, -1, 1'b1);
        check("frame_err_relock", 32'(locked), 32'd1);

        // CRC: an all-zero frame, then the same frame with one pixel set to 1.
        pat_zero = 1'b1;
        drive_frame(VT, -1, 1'b1);
        crc_a = last_ref_crc;
        poke_en = 1'b1; poke_x = 2; poke_y = 1; poke_val = 12'h001;
        drive_frame(VT, -1, 1'b1);
        crc_b = last_ref_crc;
        poke_en = 1'b0; pat_zero = 1'b0;
        dut_crc_a = frame_crc;
`ifdef VGA_RX_MONITOR_CRC_EN
        check("crc_zero_frame", 32'(frame_crc), 32'(crc_a));
`else
        check("crc_off_a", 32'(frame_crc), 32'd0);
`endif
        drive_frame(VT, -1, 1'b1);
`ifdef VGA_RX_MONITOR_CRC_EN
        check("crc_poke_frame", 32'(frame_crc), 32'(crc_b));
        check("crc_differs", 32'(frame_crc != dut_crc_a), 32'd1);
`else
        check("crc_off_b", 32'(frame_crc), 32'd0);
`endif

        // Reset mid-frame: all outputs clear at once, and relock takes two
        // fresh VS edges.
        drive_frame(4, -1, 1'b1);
        check("pre_rst_queue", 32'(exp_q.size()), 32'd0);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_locked",      32'(locked),      32'd0);
        check("mid_rst_err_cnt",     32'(err_cnt),     32'd0);
        check("mid_rst_line_len",    32'(line_len),    32'd0);
        check("mid_rst_frame_lines", 32'(frame_lines), 32'd0);
        check("mid_rst_pix",         32'({pix_valid, pix_x, pix_y}), 32'd0);
        check("mid_rst_frame_crc",   32'(frame_crc),   32'd0);
        hs = 1'b0; vs = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        drive_frame(VT, -1, 1'b0);
        check("rst_relock_vs1", 32'(locked), 32'd0);
        drive_frame(VT, -1, 1'b1);
        check("rst_relock_vs2", 32'(locked), 32'd1);

        // Saturation: 300 one-line frames, each followed by a clean frame
        // that relocks.
        for (int i = 0; i < 300; i++) begin
            drive_frame(1, -1, 1'b0);
            drive_frame(VT, -1, 1'b0);
            if (i == 0)   check("sat_first", 32'(err_cnt), 32'd1);
            if (i == 253) check("sat_254",   32'(err_cnt), 32'd254);
            if (i == 254) check("sat_255",   32'(err_cnt), 32'd255);
        end
        drive_frame(1, -1, 1'b0);
        check("sat_final",  32'(err_cnt), 32'd255);
        check("sat_relock", 32'(locked),  32'd1);

        repeat (4) @(negedge clk);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_rx_monitor.md
VGA_RX_MONITOR -- requirements
Module: vga_rx_monitor

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- H_TOTAL, 1056, pixels per line.
- V_TOTAL, 628, lines per frame.
- H_ACTIVE, 800, active pixels per line.
- V_ACTIVE, 600, active lines per frame.
- H_SYNC_TO_ACT, 216, clocks from the HS leading edge to the first active pixel.
- V_SYNC_TO_ACT, 27, lines from the VS leading edge to the first active line.
- SYNC_POL, 1'b1, asserted level of HS and VS.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, pixel clock; the block has this one clock only.
- rst_n, in, 1, asynchronous active-low reset.
- hs, in, 1, horizontal sync.
- vs, in, 1, vertical sync.
- r, in, 4, red pixel data.
- g, in, 4, green pixel data.
- b, in, 4, blue pixel data.
- pix_valid, out, 1, the outputs below carry an active pixel.
- pix_x, out, 11, active column.
- pix_y, out, 11, active row.
- pix_rgb, out, 12, {r,g,b} of that pixel.
- locked, out, 1, timing matches the parameters.
- line_len, out, 11, measured length of the last line.
- frame_lines, out, 11, measured line count of the last frame.
- frame_done, out, 1, one-cycle pulse at each frame end while locked.
- err_cnt, out, 8, number of lock losses.
- frame_crc, out, 16, pixel CRC of the last frame.

Function
REQ-003 hs, vs, r, g and b SHALL be registered once on input; all edge detection SHALL use the registered values.
- A leading edge is a transition into SYNC_POL.

REQ-004 Horizontal counter hcnt (11 bit): set to 0 on an HS leading edge, otherwise incremented, saturating at 2047.
- On an HS edge, line_len SHALL load hcnt+1.

REQ-005 Vertical counter vcnt (11 bit): set to 0 on a VS leading edge, otherwise incremented on each HS edge, saturating at 2047.
- On a VS edge, frame_lines SHALL load vcnt+1.
- When the VS and HS edges coincide, the VS rule wins (vcnt set to 0).

REQ-006 FSM states SHALL be SEARCH, ACQUIRE and LOCKED; locked=1 only in LOCKED.

REQ-007 SEARCH moves to ACQUIRE on the first VS edge.

REQ-008 ACQUIRE moves to LOCKED on the next VS edge if both conditions hold:
- every line_len captured during that frame equals H_TOTAL;
- vcnt+1 equals V_TOTAL.
Otherwise ACQUIRE stays in ACQUIRE and restarts the check.

REQ-009 LOCKED moves to ACQUIRE on either event, and err_cnt increments, saturating at 255:
- an HS edge with hcnt+1 != H_TOTAL;
- a VS edge with vcnt+1 != V_TOTAL.

REQ-010 Line-length checks SHALL be suppressed until one HS edge has been seen since reset.

REQ-011 frame_done SHALL pulse for one cycle on a VS edge that leaves the FSM in LOCKED.

REQ-012 pix_valid SHALL be 1 iff all of the following hold:
- locked;
- H_SYNC_TO_ACT <= hcnt < H_SYNC_TO_ACT+H_ACTIVE;
- V_SYNC_TO_ACT <= vcnt < V_SYNC_TO_ACT+V_ACTIVE.
pix_x = hcnt-H_SYNC_TO_ACT, pix_y = vcnt-V_SYNC_TO_ACT, and pix_rgb is the matching sample.

REQ-013 Pixel outputs SHALL be registered, with 2-clock latency from the input pins.

Reset
REQ-014 While rst_n=0 the block SHALL hold these values:
- FSM in SEARCH;
- hcnt, vcnt, line_len, frame_lines and err_cnt all 0;
- all outputs 0.
frame_crc is 16'h0000 and the internal CRC register is 16'hFFFF.

REQ-015 Reset asserted mid-frame SHALL abort acquisition immediately.
- After release, locking SHALL require a fresh SEARCH to ACQUIRE to LOCKED sequence.

Configuration
REQ-016 Macro VGA_RX_MONITOR_CRC_EN, when defined, enables the frame CRC as follows:
- algorithm CRC-16-CCITT, poly 0x1021, init 0xFFFF, no reflection;
- input is the 12-bit pix_rgb of each pix_valid cycle, MSB first, all 12 bits in one clock;
- on a VS edge, frame_crc SHALL latch the CRC and the CRC SHALL reinitialize to 0xFFFF.

REQ-017 When VGA_RX_MONITOR_CRC_EN is undefined, frame_crc SHALL be constant 16'h0000 and no CRC logic SHALL be synthesized.

Verification
REQ-018 Nominal lock: drive 1056x628 timing with syncs at SYNC_POL=1.
- locked=1 after the second VS edge.
- frame_done pulses once per frame.
- line_len=1056 and frame_lines=628.

REQ-019 Pixel mapping: input pixel 12'hABC at hcnt=216, vcnt=27.
- Two clocks later: pix_valid=1, pix_x=0, pix_y=0, pix_rgb=12'hABC.
- At hcnt=1016: pix_valid=0.

REQ-020 Line error: while locked, shorten one line to 1055 clocks.
- locked drops on that HS edge and err_cnt goes 0 to 1.
- Relock after one clean frame.

REQ-021 Frame error: while locked, send a 627-line frame.
- locked drops on the VS edge and err_cnt increments.
- err_cnt saturates at 255 after 300 bad frames.

REQ-022 Reset mid-frame: pulse rst_n low at vcnt=300.
- All outputs go to 0 asynchronously.
- locked=0 until two VS edges after release.

REQ-023 CRC (macro defined): send a constant 12'h000 frame, then a frame with one pixel changed to 12'h001.
- frame_crc matches the reference model value for each frame, and the two values differ.
- With the macro undefined, frame_crc stays 0.
